// File: rtl/prim_ram_seq_reader_pkg.sv
// Shared types for the sequential dual-port RAM reader.
package prim_ram_seq_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } state_e;

  // One buffered beat: read word plus its end-of-command tag.
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } fifo_entry_t;

endpackage

// File: rtl/prim_ram_rd_fifo2.sv
// Two-entry synchronous FIFO holding read words and their last tags.
module prim_ram_rd_fifo2 #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             wlast_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             rlast_o,
  output logic [1:0]       count_o
);

  typedef struct packed {
    logic [Width-1:0] data;
    logic             last;
  } entry_t;

  entry_t [1:0] mem_q, mem_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q].data = wdata_i;
      mem_d[wr_ptr_q].last = wlast_i;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q].data;
  assign rlast_o = mem_q[rd_ptr_q].last;
  assign count_o = count_q;

endmodule

// File: rtl/prim_ram_2p_seq_reader.sv
// Issues sequential reads on one RAM port and forwards the words as a valid/ready
// stream with a last marker.
module prim_ram_2p_seq_reader
  import prim_ram_seq_reader_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 128,
  parameter int unsigned Aw    = $clog2(Depth),
  parameter int unsigned Lw    = Aw + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [Aw-1:0]    cmd_addr_i,
  input  logic [Lw-1:0]    cmd_len_i,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic [Width-1:0] ram_rdata_i,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [Width-1:0] data_o,
  output logic             data_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e          state_q, state_d;
  logic [Aw-1:0]   addr_q, addr_d;
  logic [Lw-1:0]   remain_q, remain_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_last_q, rd_last_d;
  logic            done_q, done_d;

  logic [1:0]       fifo_count;
  logic [Width-1:0] fifo_rdata;
  logic             fifo_rlast;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             pop;
  logic [2:0]       occ;

  // Empty FIFO lets the returning word bypass straight to the output.
  always_comb begin
    fifo_empty   = (fifo_count == 2'd0);
    data_valid_o = !fifo_empty || rd_pend_q;
    data_o       = '0;
    data_last_o  = 1'b0;
    if (!fifo_empty) begin
      data_o      = fifo_rdata;
      data_last_o = fifo_rlast;
    end else if (rd_pend_q) begin
      data_o      = ram_rdata_i;
      data_last_o = rd_last_q;
    end
    pop       = data_valid_o && data_ready_i;
    fifo_pop  = pop && !fifo_empty;
    fifo_push = rd_pend_q && !(fifo_empty && pop);
    // Words buffered or in flight after this cycle's pop; never exceeds two.
    occ       = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, pop};
    ram_req_o = (state_q == StRead) && (occ < 3'd2);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    rd_pend_d = 1'b0;
    rd_last_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = StRead;
            addr_d   = cmd_addr_i;
            remain_d = cmd_len_i;
          end
        end
      end
      StRead: begin
        if (ram_req_o) begin
          rd_pend_d = 1'b1;
          rd_last_d = (remain_q == Lw'(1));
          addr_d    = (addr_q == LastAddr) ? '0 : addr_q + Aw'(1);
          remain_d  = remain_q - Lw'(1);
          if (remain_q == Lw'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && data_last_o) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      remain_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      done_q    <= done_d;
    end
  end

  prim_ram_rd_fifo2 #(
    .Width (Width)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (ram_rdata_i),
    .wlast_i (rd_last_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .rlast_o (fifo_rlast),
    .count_o (fifo_count)
  );

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign ram_addr_o  = addr_q;
  assign ram_write_o = 1'b0;
  assign ram_wdata_o = '0;
  // Zero-length commands complete from done_q; others on the last beat handshake.
  assign done_o      = done_q || ((state_q == StDrain) && pop && data_last_o);

endmodule

// File: tb/tb_prim_ram_2p_seq_reader.sv
// Directed and randomized bench for prim_ram_2p_seq_reader against a queue-based model.
module tb_prim_ram_2p_seq_reader;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 10;
  localparam int unsigned Aw    = $clog2(Depth);
  localparam int unsigned Lw    = Aw + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [Aw-1:0]    cmd_addr_i;
  logic [Lw-1:0]    cmd_len_i;
  logic             ram_req_o;
  logic             ram_write_o;
  logic [Aw-1:0]    ram_addr_o;
  logic [Width-1:0] ram_wdata_o;
  logic [Width-1:0] ram_rdata;
  logic             data_valid_o;
  logic             data_ready_i;
  logic [Width-1:0] data_o;
  logic             data_last_o;
  logic             busy_o;
  logic             done_o;

  prim_ram_2p_seq_reader #(
    .Width (Width),
    .Depth (Depth),
    .Aw    (Aw),
    .Lw    (Lw)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .ram_req_o    (ram_req_o),
    .ram_write_o  (ram_write_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_o       (data_o),
    .data_last_o  (data_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // RAM responder: data one cycle after the request, garbage otherwise.
  logic [Width-1:0] mem [Depth];
  always @(posedge clk) begin
    ram_rdata <= ram_req_o ? mem[ram_addr_o] : Width'($urandom());
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;

  int               exp_addr[$];
  logic [Width-1:0] exp_data[$];
  logic             exp_last[$];
  int               exp_dones;
  int               got_addr[$];
  int               got_req_cyc[$];
  logic [Width-1:0] got_data[$];
  logic             got_last[$];

  int               n_acc, acc1, acc_done_at, first_req, first_val;
  int               n_req, n_pop, max_occ, stab_err, done_cnt, done1, rdy_err, const_err;
  logic             rdy_at_done, done_with_last, stalled, st_last;
  logic [Width-1:0] st_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    exp_addr.delete(); exp_data.delete(); exp_last.delete(); exp_dones = 0;
    got_addr.delete(); got_req_cyc.delete(); got_data.delete(); got_last.delete();
    n_acc = 0; acc1 = -1; acc_done_at = -1; first_req = -1; first_val = -1;
    n_req = 0; n_pop = 0; max_occ = 0; stab_err = 0; done_cnt = 0; done1 = -1;
    rdy_err = 0; const_err = 0; rdy_at_done = 1'b0; done_with_last = 1'b0;
    stalled = 1'b0; st_last = 1'b0; st_data = '0;
  endtask

  // Observe one cycle of DUT behaviour (called at the falling edge).
  task automatic sample();
    int outstanding;
    if (rst_i) return;
    outstanding = n_acc - done_cnt;
    if (done_o) outstanding--;
    if (outstanding > 0 && cmd_ready_o) rdy_err++;
    if (busy_o === cmd_ready_o) rdy_err++;
    if (ram_write_o !== 1'b0 || ram_wdata_o !== '0) const_err++;
    if (cmd_valid_i && cmd_ready_o) begin
      n_acc++;
      if (n_acc == 1) acc1 = cyc;
      acc_done_at = done_cnt;
    end
    if (ram_req_o) begin
      got_addr.push_back(int'(ram_addr_o));
      got_req_cyc.push_back(cyc);
      if (first_req < 0) first_req = cyc;
      n_req++;
    end
    if (data_valid_o && first_val < 0) first_val = cyc;
    if (stalled && (!data_valid_o || data_o !== st_data || data_last_o !== st_last)) stab_err++;
    stalled = data_valid_o && !data_ready_i;
    st_data = data_o;
    st_last = data_last_o;
    if (data_valid_o && data_ready_i) begin
      got_data.push_back(data_o);
      got_last.push_back(data_last_o);
      n_pop++;
    end
    if (n_req - n_pop > max_occ) max_occ = n_req - n_pop;
    if (done_o) begin
      done_cnt++;
      if (done_cnt == 1) done1 = cyc;
      rdy_at_done    = cmd_ready_o;
      done_with_last = data_valid_o && data_ready_i && data_last_o;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    case (rdy_mode)
      0:       data_ready_i = 1'b1;
      1:       data_ready_i = ~data_ready_i;
      default: data_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1);
    check({tag, "_ram_req"}, ram_req_o, 0);
    check({tag, "_ram_addr"}, ram_addr_o, 0);
    check({tag, "_valid"}, data_valid_o, 0);
    check({tag, "_last"}, data_last_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic expect_cmd(input int addr, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (addr + i) % Depth;
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
      exp_last.push_back(i == len - 1);
    end
    exp_dones++;
  endtask

  task automatic start_cmd(input int addr, input int len);
    int target;
    target      = n_acc + 1;
    cmd_addr_i  = Aw'(addr);
    cmd_len_i   = Lw'(len);
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 60 && n_acc < target; k++) tick();
    cmd_valid_i = 1'b0;
    cmd_addr_i  = Aw'($urandom_range(0, Depth - 1));
    cmd_len_i   = Lw'($urandom_range(1, Depth));
    check("cmd_accepted", n_acc, target);
  endtask

  task automatic wait_done(input int target, input int bound);
    for (int k = 0; k < bound && done_cnt < target; k++) tick();
    check("done_within_bound", done_cnt >= target, 1);
    repeat (3) tick();
  endtask

  task automatic check_all();
    check("req_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check("req_addr", got_addr[i], exp_addr[i]);
    check("beat_count", got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check("beat_data", got_data[i], exp_data[i]);
      check("beat_last", got_last[i], exp_last[i]);
    end
    check("done_count", done_cnt, exp_dones);
    check("stall_stable", stab_err, 0);
    check("occupancy_le2", max_occ <= 2, 1);
    check("cmd_ready_busy", rdy_err, 0);
    check("ram_write_const", const_err, 0);
    check("busy_end", busy_o, 0);
    check("cmd_ready_end", cmd_ready_o, 1);
    if (exp_data.size() > 0) begin
      check("first_req_latency", first_req, acc1 + 1);
      check("first_valid_latency", first_val, acc1 + 2);
      check("done_on_last_beat", done_with_last, 1);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < Depth; i++) mem[i] = $urandom();
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = Width'(i + 'h100);
    rst_i        = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_addr_i   = '0;
    cmd_len_i    = '0;
    data_ready_i = 1'b0;
    clear();
    repeat (3) tick();
    rst_i = 1'b0;
    check_reset("reset");

    // Basic read with ready held high.
    clear(); rdy_mode = 0; data_ready_i = 1'b1;
    expect_cmd(4, 3);
    start_cmd(4, 3);
    wait_done(1, 40);
    check_all();
    for (int i = 0; i < 3 && i < got_req_cyc.size(); i++)
      check("basic_req_cycle", got_req_cyc[i], acc1 + 1 + i);
    check("basic_done_cycle", done1, acc1 + 4);

    // Backpressure with ready toggling.
    clear(); rdy_mode = 1; data_ready_i = 1'b1;
    expect_cmd(0, 8);
    start_cmd(0, 8);
    wait_done(1, 80);
    check_all();

    // Address wrap past Depth-1.
    clear(); rdy_mode = 0; data_ready_i = 1'b1;
    expect_cmd(8, 4);
    start_cmd(8, 4);
    wait_done(1, 40);
    check_all();

    // Zero length.
    clear(); rdy_mode = 0;
    expect_cmd(5, 0);
    start_cmd(5, 0);
    wait_done(1, 20);
    check_all();
    check("zero_done_cycle", done1, acc1 + 1);
    check("zero_ready_at_done", rdy_at_done, 1);

    // Second command presented while busy.
    clear(); rdy_mode = 2;
    fill_random();
    expect_cmd(2, 5);
    expect_cmd(7, 3);
    start_cmd(2, 5);
    start_cmd(7, 3);
    wait_done(2, 120);
    check_all();
    check("second_after_done", acc_done_at, 1);

    // Reset in the middle of a transfer.
    clear(); rdy_mode = 0; data_ready_i = 1'b1;
    start_cmd(3, 6);
    for (int k = 0; k < 40 && n_pop < 2; k++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset("mid_reset");
    clear();
    repeat (4) tick();
    check("no_done_after_reset", done_cnt, 0);
    check("no_req_after_reset", n_req, 0);
    clear();
    expect_cmd(3, 6);
    start_cmd(3, 6);
    wait_done(1, 60);
    check_all();

    // Full length from a non-zero start.
    clear(); rdy_mode = 2;
    fill_random();
    expect_cmd(7, Depth);
    start_cmd(7, Depth);
    wait_done(1, 120);
    check_all();

    // Random commands under random backpressure.
    for (int t = 0; t < 8; t++) begin
      int a, l;
      a = $urandom_range(0, Depth - 1);
      l = $urandom_range(0, Depth);
      clear(); rdy_mode = 2;
      fill_random();
      expect_cmd(a, l);
      start_cmd(a, l);
      wait_done(1, 120);
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
